// File: rtl/attn_pkg.sv
// attn_pkg: shared FSM state, fixed-point format constants and clog2 helper
// for the attention score engine.
package attn_pkg;

    typedef enum logic [1:0] {ACCUM, REDUCE, EXPW, PUSH} state_t;

    // Integer bits of the exponent formats: input Q1.f (sign + 1), output UQ3.f.
    localparam int EXP_IN_INT  = 2;
    localparam int EXP_OUT_INT = 3;

    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/attn_exp_lut.sv
// attn_exp_lut: combinational e^x table, signed Q1.(EXP_IN_W-2) in,
// unsigned UQ3.(EXP_OUT_W-3) out, rounded to nearest and clamped.
module attn_exp_lut import attn_pkg::*; #(
    parameter int EXP_IN_W  = 8,
    parameter int EXP_OUT_W = 9
) (
    input  logic [EXP_IN_W-1:0]  x,
    output logic [EXP_OUT_W-1:0] y
);
    localparam int EXP_IN_FRAC  = EXP_IN_W - EXP_IN_INT;
    localparam int EXP_OUT_FRAC = EXP_OUT_W - EXP_OUT_INT;
    localparam int N = 1 << EXP_IN_W;

    // Every table index is a constant, so the real arithmetic folds away at elaboration.
    function automatic logic [EXP_OUT_W-1:0] exp_code(input int idx);
        real v;
        v = $exp(real'(idx >= N / 2 ? idx - N : idx) / real'(1 << EXP_IN_FRAC))
            * real'(1 << EXP_OUT_FRAC) + 0.5;
        return v >= real'((1 << EXP_OUT_W) - 1) ? '1 : EXP_OUT_W'($rtoi(v));
    endfunction

    logic [EXP_OUT_W-1:0] tbl [N];

    for (genvar i = 0; i < N; i++) begin : g_tbl
        assign tbl[i] = exp_code(i);
    end

    assign y = tbl[x];

endmodule

// File: rtl/attn_score_engine.sv
// attn_score_engine: streamed Q.K dot product -> scale/saturate -> e^x LUT -> output FIFO.
// Define ATTN_EXPSUM_EN to add the per-row exponent sum outputs (sum_vld, sum_data).
module attn_score_engine import attn_pkg::*; #(
    parameter int DW          = 8,
    parameter int VEC_LEN     = 4,
    parameter int SCALE_SHIFT = 1,
    parameter int EXP_IN_W    = 8,
    parameter int EXP_OUT_W   = 9,
    parameter int FIFO_DEPTH  = 4,
    parameter int ROW_LEN     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [DW-1:0]                in_q,
    input  logic [DW-1:0]                in_k,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [EXP_OUT_W-1:0]         out_data,
    output logic [clog2(FIFO_DEPTH):0]   out_level,
    output logic                         sat_sticky
`ifdef ATTN_EXPSUM_EN
    ,
    output logic                         sum_vld,
    output logic [EXP_OUT_W+clog2(ROW_LEN)-1:0] sum_data
`endif
);
    localparam int CW    = clog2(VEC_LEN);
    localparam int ACC_W = 2 * DW + CW;
    localparam int SH    = 2 * (DW - 1) + SCALE_SHIFT - (EXP_IN_W - 2);
    localparam int AW    = clog2(FIFO_DEPTH);
    localparam logic signed [ACC_W-1:0] EMAX = ACC_W'((1 << (EXP_IN_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] EMIN = ~EMAX;

    if (SH < 0 || VEC_LEN < 2 || (VEC_LEN & (VEC_LEN - 1)) != 0 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || ROW_LEN < 2 || ACC_W < EXP_IN_W) begin : g_bad
        $error("attn_score_engine: unsupported parameter combination");
    end

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic signed [2*DW-1:0]   prod;
    logic signed [ACC_W-1:0]  prod_x, acc, shifted;
    logic                     sat_hi, sat_lo, accept, push, pop, full;
    logic [EXP_IN_W-1:0]      exp_in;
    logic [EXP_OUT_W-1:0]     exp_out, lut_out;
    logic [EXP_OUT_W-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;

    assign prod    = $signed(in_q) * $signed(in_k);
    assign prod_x  = {{CW{prod[2*DW-1]}}, prod};
    assign shifted = acc >>> SH;
    assign sat_hi  = shifted > EMAX;
    assign sat_lo  = shifted < EMIN;
    assign in_rdy  = !rst && state == ACCUM;
    assign accept  = in_vld && in_rdy;
    assign out_vld = out_level != '0;
    assign out_data = out_vld ? mem[rd_ptr] : '0;
    assign full    = out_level == (AW + 1)'(FIFO_DEPTH);
    assign pop     = out_vld && out_rdy;
    // A full FIFO still accepts the write when the head leaves in the same cycle.
    assign push    = state == PUSH && (!full || pop);

    attn_exp_lut #(.EXP_IN_W(EXP_IN_W), .EXP_OUT_W(EXP_OUT_W)) u_lut (
        .x(exp_in),
        .y(lut_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ACCUM;
            cnt        <= '0;
            acc        <= '0;
            exp_in     <= '0;
            exp_out    <= '0;
            sat_sticky <= 1'b0;
        end else begin
            case (state)
                ACCUM: if (accept) begin
                    acc <= cnt == '0 ? prod_x : acc + prod_x;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(VEC_LEN - 1)) state <= REDUCE;
                end
                REDUCE: begin
                    exp_in     <= sat_hi ? EMAX[EXP_IN_W-1:0] : sat_lo ? EMIN[EXP_IN_W-1:0]
                                                                       : shifted[EXP_IN_W-1:0];
                    sat_sticky <= sat_sticky | sat_hi | sat_lo;
                    state      <= EXPW;
                end
                EXPW: begin
                    exp_out <= lut_out;
                    state   <= PUSH;
                end
                PUSH: if (push) state <= ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_level <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(push);
            rd_ptr    <= rd_ptr + AW'(pop);
            out_level <= out_level + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= exp_out;
    end

`ifdef ATTN_EXPSUM_EN
    localparam int RW = clog2(ROW_LEN);
    localparam int SW = EXP_OUT_W + RW;

    logic [RW-1:0] row_cnt;
    logic [SW-1:0] run_sum, next_sum;

    assign next_sum = run_sum + SW'(exp_out);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_cnt  <= '0;
            run_sum  <= '0;
            sum_vld  <= 1'b0;
            sum_data <= '0;
        end else begin
            sum_vld <= 1'b0;
            if (push && row_cnt == RW'(ROW_LEN - 1)) begin
                sum_vld  <= 1'b1;
                sum_data <= next_sum;
                run_sum  <= '0;
                row_cnt  <= '0;
            end else if (push) begin
                run_sum <= next_sum;
                row_cnt <= row_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
